write_back_unit: RTL and testbench
==================================

# write_back_unit

Parametrised write-back stage for the pipelined core. It selects the result from the ALU, data memory, the link address or the immediate. Load data is aligned and extended by size and signedness, and misaligned loads are detected. It registers the register-file write port and doubles as the WB forwarding source. A retired-instruction counter is maintained.

## Interface
Parameters:
- DATA_W, 32: datapath width; legal values 32 or 64
- REG_ADDR_W, 5: register index width
- CNT_W, 32: width of the retire counter
- OFF_W, $clog2(DATA_W/8): byte-offset width (derived, not overridden)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  MEM/WB payload valid this cycle
- in_ready  out  1  stage accepts payload; equals !hold
- hold  in  1  stall from hazard unit
- flush  in  1  kill the payload presented this cycle
- wb_sel  in  2  result source: 0 ALU, 1 MEM, 2 LINK, 3 IMM
- alu_data_out  in  DATA_W  ALU result
- dm_data_out  in  DATA_W  raw data-memory read word
- link_data  in  DATA_W  return address (PC+4)
- imm_data  in  DATA_W  upper-immediate value
- ld_size  in  2  0 byte, 1 half, 2 word, 3 double
- ld_unsigned  in  1  zero-extend when 1, sign-extend when 0
- ld_off  in  OFF_W  byte offset of the load address
- rd_addr  in  REG_ADDR_W  destination register
- reg_write  in  1  instruction writes rd
- rf_we  out  1  register-file write enable / forward valid
- rf_waddr  out  REG_ADDR_W  write index
- rf_wdata  out  DATA_W  write data (wb_data)
- misalign_err  out  1  one-cycle pulse for a misaligned load
- retire_count  out  CNT_W  retired instruction count

## Operation
- Capture condition: in_valid & !hold & !flush on a rising edge of clk.
- Source mux uses wb_sel. For MEM, the data passes through the load formatter:
  - byte: dm_data_out[8*ld_off +: 8]
  - half: dm_data_out[16*(ld_off>>1) +: 16]
  - word: dm_data_out[32*(ld_off>>2) +: 32]
  - double: full word
  - Little-endian. The selected field is extended to DATA_W according to ld_unsigned.
- With DATA_W=32, ld_size 3 is treated as word.
- Misaligned when wb_sel=MEM and any of the following holds; never flagged for other sources:
  - half with ld_off[0]≠0
  - word with ld_off[1:0]≠0
  - double with ld_off≠0
- On capture, the registered write is:
  - rf_we = reg_write & (rd_addr≠0) & !misaligned
  - rf_waddr = rd_addr
  - rf_wdata = formatted result
  - misalign_err = misaligned
- With no capture, rf_we and misalign_err are 0 next cycle. rf_waddr and rf_wdata hold their previous values.
- retire_count increments by 1 per captured, non-misaligned instruction, including reg_write=0 and rd=0. It wraps modulo 2^CNT_W.
- Priority: rst_n low > flush > hold > capture.

## Timing
- Latency is 1 cycle: a payload captured on edge N drives rf_* after edge N, so it is visible during cycle N+1.
- rf_we is high for exactly one cycle per write; a hold never repeats a write.
- in_ready is combinational from hold only.
- Reset (rst_n low at an edge): rf_we=0, rf_waddr=0, rf_wdata=0, misalign_err=0, retire_count=0. A payload presented in the reset cycle is dropped.
- Deasserting reset mid-stream means the first capture is the next valid edge.
- flush and hold together: flush wins, and the result is the same (bubble).
- Back-to-back captures every cycle are supported at full throughput.

## Structure
- Package wb_pkg holds:
  - WB_ALU, WB_MEM, WB_LINK, WB_IMM localparams for wb_sel
  - LD_BYTE, LD_HALF, LD_WORD, LD_DOUBLE localparams for ld_size
- Sub-module load_formatter is combinational. It takes dm_data_out, ld_size, ld_unsigned and ld_off, and produces formatted data and the misaligned flag.
- write_back_unit contains the source mux, the output registers and the counter.

## Test plan
- ALU path: wb_sel=0, alu=5, dm=4, rd=3, reg_write=1 → next cycle rf_we=1, rf_waddr=3, rf_wdata=5; retire_count 0→1.
- Signed byte load: wb_sel=1, dm=0x80FF7F01, ld_size=0, ld_off=3, ld_unsigned=0 → rf_wdata=0xFFFFFF80. Same with ld_unsigned=1 → 0x00000080.
- Misaligned half: ld_size=1, ld_off=1 → rf_we=0, misalign_err pulses once, retire_count unchanged.
- rd=0 with reg_write=1 → rf_we=0, retire_count increments.
- hold=1 for 3 cycles then flush=1 with in_valid=1:
  - hold cycles: in_ready=0 and rf_we=0
  - flush cycle: no capture
  - retire_count unchanged throughout
- Reset mid-stream: captures every cycle, rst_n low for 1 cycle → all outputs 0 next cycle, retire_count=0, counting resumes from 1. Also verify CNT_W=4 wraps 15→0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result-source selects and load sizes.
package wb_pkg;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  localparam logic [1:0] LD_BYTE   = 2'd0;
  localparam logic [1:0] LD_HALF   = 2'd1;
  localparam logic [1:0] LD_WORD   = 2'd2;
  localparam logic [1:0] LD_DOUBLE = 2'd3;

endpackage

// File: rtl/load_formatter.sv
// Combinational load aligner: picks the addressed little-endian field of the
// memory word, sign/zero-extends it and flags misaligned accesses.
module load_formatter
  import wb_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] dm_data_out,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  input  logic [OFF_W-1:0]  ld_off,
  output logic [DATA_W-1:0] load_data,
  output logic              misaligned
);

  localparam int NUM_BYTES = DATA_W / 8;
  localparam int NUM_HALFS = DATA_W / 16;
  localparam int NUM_WORDS = DATA_W / 32;

  logic [7:0]  byte_lane [NUM_BYTES];
  logic [15:0] half_lane [NUM_HALFS];
  logic [31:0] word_lane [NUM_WORDS];

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] word_sel;
  logic [1:0]  eff_size;
  logic        ext_bit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
      assign byte_lane[gi] = dm_data_out[8*gi +: 8];
    end
    for (gi = 0; gi < NUM_HALFS; gi++) begin : g_half
      assign half_lane[gi] = dm_data_out[16*gi +: 16];
    end
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      assign word_lane[gi] = dm_data_out[32*gi +: 32];
    end
    // A 32-bit datapath has a single word lane, so the offset does not steer it.
    if (NUM_WORDS == 1) begin : g_word_sel_single
      assign word_sel = word_lane[0];
    end else begin : g_word_sel_multi
      assign word_sel = word_lane[ld_off[OFF_W-1]];
    end
  endgenerate

  assign byte_sel = byte_lane[ld_off];
  assign half_sel = half_lane[ld_off[OFF_W-1:1]];

  // A double on a 32-bit datapath degenerates to a word access.
  assign eff_size = (DATA_W == 32 && ld_size == LD_DOUBLE) ? LD_WORD : ld_size;

  always_comb begin
    load_data  = dm_data_out;
    misaligned = 1'b0;
    ext_bit    = 1'b0;
    case (eff_size)
      LD_BYTE: begin
        ext_bit   = !ld_unsigned && byte_sel[7];
        load_data = {{(DATA_W-8){ext_bit}}, byte_sel};
      end
      LD_HALF: begin
        ext_bit    = !ld_unsigned && half_sel[15];
        load_data  = {{(DATA_W-16){ext_bit}}, half_sel};
        misaligned = ld_off[0];
      end
      LD_WORD: begin
        if (DATA_W > 32) begin
          ext_bit   = !ld_unsigned && word_sel[31];
          load_data = {{(DATA_W-32){ext_bit}}, word_sel};
        end else begin
          load_data = DATA_W'(word_sel);
        end
        misaligned = |ld_off[1:0];
      end
      default: begin
        load_data  = dm_data_out;
        misaligned = |ld_off;
      end
    endcase
  end

endmodule

// File: rtl/write_back_unit.sv
// Write-back stage: selects the result source, registers the register-file
// write port (also the WB forwarding source) and counts retired instructions.
module write_back_unit
  import wb_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int REG_ADDR_W = 5,
  parameter  int CNT_W      = 32,
  localparam int OFF_W      = $clog2(DATA_W/8)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  hold,
  input  logic                  flush,
  input  logic [1:0]            wb_sel,
  input  logic [DATA_W-1:0]     alu_data_out,
  input  logic [DATA_W-1:0]     dm_data_out,
  input  logic [DATA_W-1:0]     link_data,
  input  logic [DATA_W-1:0]     imm_data,
  input  logic [1:0]            ld_size,
  input  logic                  ld_unsigned,
  input  logic [OFF_W-1:0]      ld_off,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  reg_write,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  misalign_err,
  output logic [CNT_W-1:0]      retire_count
);

  logic [DATA_W-1:0]     load_data;
  logic                  load_misaligned;
  logic                  misaligned;
  logic                  capture;
  logic [DATA_W-1:0]     wb_data_next;

  logic                  rf_we_reg;
  logic [REG_ADDR_W-1:0] rf_waddr_reg;
  logic [DATA_W-1:0]     rf_wdata_reg;
  logic                  misalign_err_reg;
  logic [CNT_W-1:0]      retire_count_reg;

  load_formatter #(
    .DATA_W (DATA_W)
  ) u_load_formatter (
    .dm_data_out (dm_data_out),
    .ld_size     (ld_size),
    .ld_unsigned (ld_unsigned),
    .ld_off      (ld_off),
    .load_data   (load_data),
    .misaligned  (load_misaligned)
  );

  assign in_ready = !hold;
  // flush outranks hold; either one turns the cycle into a bubble.
  assign capture    = in_valid && !hold && !flush;
  assign misaligned = (wb_sel == WB_MEM) && load_misaligned;

  always_comb begin
    wb_data_next = alu_data_out;
    case (wb_sel)
      WB_ALU:  wb_data_next = alu_data_out;
      WB_MEM:  wb_data_next = load_data;
      WB_LINK: wb_data_next = link_data;
      WB_IMM:  wb_data_next = imm_data;
      default: wb_data_next = alu_data_out;
    endcase
  end

  // Address and data hold between writes so the forwarding path stays stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_reg        <= 1'b0;
      rf_waddr_reg     <= '0;
      rf_wdata_reg     <= '0;
      misalign_err_reg <= 1'b0;
    end else if (capture) begin
      rf_we_reg        <= reg_write && (rd_addr != '0) && !misaligned;
      rf_waddr_reg     <= rd_addr;
      rf_wdata_reg     <= wb_data_next;
      misalign_err_reg <= misaligned;
    end else begin
      rf_we_reg        <= 1'b0;
      misalign_err_reg <= 1'b0;
    end
  end

  // Every accepted instruction retires unless it faulted, even without a write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_count_reg <= '0;
    end else if (capture && !misaligned) begin
      retire_count_reg <= retire_count_reg + CNT_W'(1);
    end
  end

  assign rf_we        = rf_we_reg;
  assign rf_waddr     = rf_waddr_reg;
  assign rf_wdata     = rf_wdata_reg;
  assign misalign_err = misalign_err_reg;
  assign retire_count = retire_count_reg;

endmodule

// File: tb/tb_write_back_unit.sv
// Bench for write_back_unit: a 32-bit/4-bit-counter instance and a 64-bit
// instance driven together, checked against a per-cycle reference model.
module tb_write_back_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, hold, flush, ld_unsigned, reg_write;
  logic [1:0]  wb_sel, ld_size;
  logic [63:0] alu, dm, link, imm;
  logic [2:0]  ld_off;
  logic [4:0]  rd;

  logic        a_ready, a_we, a_mis;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic [3:0]  a_cnt;
  logic        b_ready, b_we, b_mis;
  logic [4:0]  b_waddr;
  logic [63:0] b_wdata;
  logic [31:0] b_cnt;

  write_back_unit #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ready),
    .hold(hold), .flush(flush), .wb_sel(wb_sel),
    .alu_data_out(alu[31:0]), .dm_data_out(dm[31:0]),
    .link_data(link[31:0]), .imm_data(imm[31:0]),
    .ld_size(ld_size), .ld_unsigned(ld_unsigned), .ld_off(ld_off[1:0]),
    .rd_addr(rd), .reg_write(reg_write),
    .rf_we(a_we), .rf_waddr(a_waddr), .rf_wdata(a_wdata),
    .misalign_err(a_mis), .retire_count(a_cnt)
  );

  write_back_unit #(.DATA_W(64), .REG_ADDR_W(5), .CNT_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ready),
    .hold(hold), .flush(flush), .wb_sel(wb_sel),
    .alu_data_out(alu), .dm_data_out(dm),
    .link_data(link), .imm_data(imm),
    .ld_size(ld_size), .ld_unsigned(ld_unsigned), .ld_off(ld_off),
    .rd_addr(rd), .reg_write(reg_write),
    .rf_we(b_we), .rf_waddr(b_waddr), .rf_wdata(b_wdata),
    .misalign_err(b_mis), .retire_count(b_cnt)
  );

  int checks = 0;
  int passes = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: the instruction's result and fault for a datapath of dw bits.
  function automatic logic [64:0] model(input int dw);
    logic [63:0] dmask, field, fmask, res;
    int off, nb, base;
    logic mis;
    dmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    off   = (dw == 64) ? int'(ld_off) : int'(ld_off) % 4;
    nb    = 1 << ld_size;
    if (nb * 8 > dw) nb = dw / 8;
    base  = off - (off % nb);
    mis   = (wb_sel == 2'd1) && ((off % nb) != 0);
    field = (dm & dmask) >> (8 * base);
    if (nb < 8) begin
      fmask = (64'd1 << (8 * nb)) - 64'd1;
      field = field & fmask;
      if (!ld_unsigned && field[8*nb-1]) field = field | ~fmask;
    end
    case (wb_sel)
      2'd0:    res = alu;
      2'd1:    res = field;
      2'd2:    res = link;
      default: res = imm;
    endcase
    return {mis, res & dmask};
  endfunction

  logic        ea_we, ea_mis, eb_we, eb_mis;
  logic [4:0]  ea_waddr, eb_waddr;
  logic [63:0] ea_wdata, eb_wdata;
  logic [3:0]  ea_cnt;
  logic [31:0] eb_cnt;

  always @(posedge clk) begin
    logic [64:0] ra, rb;
    ra = model(32);
    rb = model(64);
    if (!rst_n) begin
      ea_we <= 0; ea_mis <= 0; ea_waddr <= 0; ea_wdata <= 0; ea_cnt <= 0;
      eb_we <= 0; eb_mis <= 0; eb_waddr <= 0; eb_wdata <= 0; eb_cnt <= 0;
    end else if (in_valid && !hold && !flush) begin
      ea_we <= reg_write && rd != 0 && !ra[64];
      ea_mis <= ra[64]; ea_waddr <= rd; ea_wdata <= ra[63:0];
      if (!ra[64]) ea_cnt <= ea_cnt + 4'd1;
      eb_we <= reg_write && rd != 0 && !rb[64];
      eb_mis <= rb[64]; eb_waddr <= rd; eb_wdata <= rb[63:0];
      if (!rb[64]) eb_cnt <= eb_cnt + 32'd1;
    end else begin
      ea_we <= 0; ea_mis <= 0; eb_we <= 0; eb_mis <= 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (started) begin
      chk("a_ready", a_ready, !hold);
      chk("a_we", a_we, ea_we);
      chk("a_waddr", a_waddr, ea_waddr);
      chk("a_wdata", a_wdata, ea_wdata);
      chk("a_mis", a_mis, ea_mis);
      chk("a_cnt", a_cnt, ea_cnt);
      chk("b_ready", b_ready, !hold);
      chk("b_we", b_we, eb_we);
      chk("b_waddr", b_waddr, eb_waddr);
      chk("b_wdata", b_wdata, eb_wdata);
      chk("b_mis", b_mis, eb_mis);
      chk("b_cnt", b_cnt, eb_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set(input logic [1:0] s, input logic [63:0] a_v, input logic [63:0] d_v,
                     input logic [1:0] sz, input logic u, input logic [2:0] o,
                     input logic [4:0] r, input logic w);
    in_valid = 1; hold = 0; flush = 0;
    wb_sel = s; alu = a_v; dm = d_v; ld_size = sz; ld_unsigned = u;
    ld_off = o; rd = r; reg_write = w;
  endtask

  typedef struct {
    logic [1:0]  s;
    logic [1:0]  sz;
    logic        u;
    logic [2:0]  o;
    logic [63:0] d;
  } vec_t;
  vec_t vecs[10];

  initial begin
    link = 64'h0000_0040_0000_1004;
    imm  = 64'h1234_5000_ABCD_E000;
    rst_n = 0;
    set(2'd0, 64'd77, 64'd0, 2'd0, 1'b0, 3'd0, 5'd9, 1'b1);
    tick();
    started = 1;
    tick();
    chk("lit_rst_cnt", a_cnt, 0);
    chk("lit_rst_we", b_we, 0);
    rst_n = 1;

    set(2'd0, 64'd5, 64'd4, 2'd0, 1'b0, 3'd0, 5'd3, 1'b1);
    tick();
    chk("lit_alu_we", a_we, 1);
    chk("lit_alu_waddr", a_waddr, 3);
    chk("lit_alu_wdata", a_wdata, 5);
    chk("lit_alu_cnt", a_cnt, 1);

    set(2'd1, 64'd0, 64'h0123_4567_80FF_7F01, 2'd0, 1'b0, 3'd3, 5'd7, 1'b1);
    tick();
    chk("lit_lb_a", a_wdata, 64'h0000_0000_FFFF_FF80);
    chk("lit_lb_b", b_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    ld_unsigned = 1;
    tick();
    chk("lit_lbu_a", a_wdata, 64'h80);

    set(2'd1, 64'd0, 64'h0123_4567_80FF_7F01, 2'd1, 1'b0, 3'd1, 5'd8, 1'b1);
    tick();
    chk("lit_mis_we", a_we, 0);
    chk("lit_mis_err", a_mis, 1);
    chk("lit_mis_cnt", a_cnt, 3);
    in_valid = 0;
    tick();
    chk("lit_mis_pulse", a_mis, 0);

    set(2'd0, 64'd11, 64'd0, 2'd0, 1'b0, 3'd0, 5'd0, 1'b1);
    tick();
    chk("lit_rd0_we", a_we, 0);
    chk("lit_rd0_cnt", a_cnt, 4);

    set(2'd0, 64'd9, 64'd0, 2'd0, 1'b0, 3'd0, 5'd4, 1'b1);
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit_hold_ready", a_ready, 0);
      chk("lit_hold_we", a_we, 0);
    end
    hold = 0; flush = 1;
    tick();
    chk("lit_flush_we", a_we, 0);
    chk("lit_flush_cnt", a_cnt, 4);
    hold = 1;
    tick();
    chk("lit_flush_hold_we", b_we, 0);
    hold = 0; flush = 0;
    tick();
    chk("lit_after_we", a_we, 1);
    chk("lit_after_wdata", a_wdata, 9);
    chk("lit_after_cnt", a_cnt, 5);

    vecs[0] = '{2'd1, 2'd2, 1'b0, 3'd4, 64'hF000_0001_0000_0002};
    vecs[1] = '{2'd1, 2'd3, 1'b0, 3'd4, 64'hF000_0001_0000_0002};
    vecs[2] = '{2'd1, 2'd3, 1'b0, 3'd0, 64'h8765_4321_DEAD_BEEF};
    vecs[3] = '{2'd1, 2'd1, 1'b0, 3'd6, 64'h8001_0000_0000_7FFF};
    vecs[4] = '{2'd1, 2'd1, 1'b1, 3'd2, 64'h0000_0000_9ABC_1234};
    vecs[5] = '{2'd1, 2'd2, 1'b1, 3'd2, 64'h0000_0000_9ABC_1234};
    vecs[6] = '{2'd2, 2'd1, 1'b0, 3'd1, 64'h0};
    vecs[7] = '{2'd3, 2'd2, 1'b0, 3'd3, 64'h0};
    vecs[8] = '{2'd1, 2'd0, 1'b0, 3'd6, 64'h00AB_0000_0000_00FE};
    vecs[9] = '{2'd1, 2'd2, 1'b1, 3'd0, 64'hFFFF_FFFF_8000_0000};
    for (int i = 0; i < 10; i++) begin
      set(vecs[i].s, 64'd0, vecs[i].d, vecs[i].sz, vecs[i].u, vecs[i].o, 5'(10 + i), 1'b1);
      tick();
      if (i == 0) begin
        chk("lit_lw_off4_b", b_wdata, 64'hFFFF_FFFF_F000_0001);
        chk("lit_lw_off4_a", a_wdata, 64'h2);
      end
      if (i == 1) begin
        chk("lit_ld_off4_b_mis", b_mis, 1);
        chk("lit_ld_as_lw_a_we", a_we, 1);
      end
    end

    for (int i = 0; i < 5; i++) begin
      set(2'd0, 64'(100 + i), 64'd0, 2'd0, 1'b0, 3'd0, 5'(1 + i), 1'b1);
      tick();
    end
    rst_n = 0;
    tick();
    chk("lit_mid_rst_we", a_we, 0);
    chk("lit_mid_rst_waddr", a_waddr, 0);
    chk("lit_mid_rst_wdata", b_wdata, 0);
    chk("lit_mid_rst_cnt", b_cnt, 0);
    rst_n = 1;
    for (int i = 1; i <= 16; i++) begin
      set(2'd0, 64'(200 + i), 64'd0, 2'd0, 1'b0, 3'd0, 5'd6, 1'b1);
      tick();
      if (i == 1) chk("lit_resume_cnt", b_cnt, 1);
      if (i == 15) chk("lit_cnt15", a_cnt, 15);
      if (i == 16) begin
        chk("lit_wrap", a_cnt, 0);
        chk("lit_no_wrap64", b_cnt, 16);
      end
    end
    in_valid = 0;
    tick();
    tick();
    started = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
